fifo_param: RTL and testbench

Parametrised synchronous FIFO for the transaction-layer datapath, the successor to the fixed 12-bit FIFO. It adds parametrised width and depth, runtime-programmable almost-full/almost-empty thresholds, an occupancy count, full/empty flags, a read-valid strobe, and sticky overflow/underflow error flags. It sits between transaction-layer producers and consumers in the single `clk` domain.

---
 rtl/fifo_param_pkg.sv | 15 +
 rtl/fifo_param_if.sv | 38 +++
 rtl/fifo_mem.sv | 31 +++
 rtl/fifo_param.sv | 77 +++++++
 tb/tb_fifo_param.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fifo_param_pkg.sv
// rtl/fifo_param_pkg.sv - shared defaults and sizing helper for the parametrised FIFO
package fifo_param_pkg;

  localparam int DEFAULT_WIDTH = 12;
  localparam int DEFAULT_DEPTH = 8;

  // Ceiling log2, usable in parameter context.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// rtl/fifo_param_if.sv - producer/consumer and status bundle of the parametrised FIFO
interface fifo_param_if
  import fifo_param_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);
  localparam int ADDR_W = clog2(DEPTH);

  logic              push;
  logic [WIDTH-1:0]  data_in;
  logic              pop;
  logic [ADDR_W:0]   af_thresh;
  logic [ADDR_W:0]   ae_thresh;
  logic              err_clr;
  logic [WIDTH-1:0]  data_out;
  logic              valid_out;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, data_in, pop, af_thresh, ae_thresh, err_clr,
    input  data_out, valid_out, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  push, data_in, pop, af_thresh, ae_thresh, err_clr,
    output data_out, valid_out, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port RAM, one write port and one registered read port
module fifo_mem #(
  parameter int WIDTH  = 12,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array is never cleared; stale words are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-before-write on the same address returns the old word, which is
  // what a simultaneous push/pop at full occupancy needs.
  always_ff @(posedge clk) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with thresholds, count and sticky errors
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  fifo_param_if.slave   bus
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              valid_out;
  logic              overflow;
  logic              underflow;
  logic              full;
  logic              empty;
  logic              push_acc;
  logic              pop_acc;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_acc  = bus.pop && !empty;
  // A push at full is taken only when a pop frees a slot in the same cycle.
  assign push_acc = bus.push && (!full || pop_acc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + ADDR_W'(1);
      if (push_acc && !pop_acc)      count <= count + CNT_W'(1);
      else if (pop_acc && !push_acc) count <= count - CNT_W'(1);
      valid_out <= pop_acc;
      // A new error wins over a clear in the same cycle.
      overflow  <= (bus.push && !push_acc) || (overflow && !bus.err_clr);
      underflow <= (bus.pop && empty) || (underflow && !bus.err_clr);
    end
  end

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_en   (pop_acc),
    .rd_addr (rd_ptr),
    .rd_data (bus.data_out)
  );

  assign bus.valid_out    = valid_out;
  assign bus.count        = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= bus.af_thresh);
  assign bus.almost_empty = (count <= bus.ae_thresh);
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - self-checking bench for fifo_param against a queue reference model
module tb_fifo_param;

  localparam int WIDTH = 12;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();

  fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout = '0;
  bit               m_valid = 1'b0;
  bit               m_ovf = 1'b0;
  bit               m_udf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, "/count"},        32'(bus.count),        32'(n));
    check({tag, "/full"},         32'(bus.full),         32'(n == DEPTH));
    check({tag, "/empty"},        32'(bus.empty),        32'(n == 0));
    check({tag, "/almost_full"},  32'(bus.almost_full),  32'(n >= int'(bus.af_thresh)));
    check({tag, "/almost_empty"}, 32'(bus.almost_empty), 32'(n <= int'(bus.ae_thresh)));
    check({tag, "/valid_out"},    32'(bus.valid_out),    32'(m_valid));
    check({tag, "/data_out"},     32'(bus.data_out),     32'(m_dout));
    check({tag, "/overflow"},     32'(bus.overflow),     32'(m_ovf));
    check({tag, "/underflow"},    32'(bus.underflow),    32'(m_udf));
  endtask

  // One clock: drive inputs, advance the reference model on the edge, compare after it.
  task automatic cycle(input bit p, input logic [WIDTH-1:0] d, input bit r, input bit c,
                       input string tag);
    bit pop_ok;
    bit push_ok;
    bit was_full;
    bit was_empty;
    bus.push    = p;
    bus.data_in = d;
    bus.pop     = r;
    bus.err_clr = c;
    @(posedge clk);
    if (!reset) begin
      q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      pop_ok    = r && !was_empty;
      push_ok   = p && (!was_full || pop_ok);
      m_valid   = pop_ok;
      if (pop_ok)  m_dout = q.pop_front();
      if (push_ok) q.push_back(d);
      m_ovf = (p && !push_ok) || (m_ovf && !c);
      m_udf = (r && was_empty) || (m_udf && !c);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.push      = 1'b0;
    bus.data_in   = '0;
    bus.pop       = 1'b0;
    bus.err_clr   = 1'b0;
    bus.af_thresh = 4'd6;
    bus.ae_thresh = 4'd1;

    // Reset and basic fill/drain
    reset = 1'b0;
    repeat (3) cycle(0, '0, 0, 0, "reset");
    check("reset_empty", 32'(bus.empty), 32'd1);
    check("reset_almost_empty", 32'(bus.almost_empty), 32'd1);
    reset = 1'b1;
    cycle(1, 12'h00A, 0, 0, "push_a");
    cycle(1, 12'h00B, 0, 0, "push_b");
    check("two_count", 32'(bus.count), 32'd2);
    cycle(0, '0, 1, 0, "pop_a");
    check("pop_a_data", 32'(bus.data_out), 32'h00A);
    cycle(0, '0, 1, 0, "pop_b");
    check("pop_b_data", 32'(bus.data_out), 32'h00B);
    check("drained_empty", 32'(bus.empty), 32'd1);

    // Fill to full, overflow, then push+pop at full
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1, WIDTH'(i), 0, 0, "fill");
      if (i == 5) check("af_below", 32'(bus.almost_full), 32'd0);
      if (i == 6) check("af_at6", 32'(bus.almost_full), 32'd1);
    end
    check("full_at8", 32'(bus.full), 32'd1);
    cycle(1, 12'h0FF, 0, 0, "overflow_push");
    check("overflow_set", 32'(bus.overflow), 32'd1);
    cycle(0, '0, 0, 1, "clr_ovf");
    cycle(1, 12'h100, 1, 0, "push_pop_full");
    check("pp_full_count", 32'(bus.count), 32'd8);
    check("pp_full_data", 32'(bus.data_out), 32'h001);
    check("pp_full_no_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) cycle(0, '0, 1, 0, "drain");
    check("last_is_0x100", 32'(bus.data_out), 32'h100);

    // Underflow
    cycle(0, '0, 1, 0, "pop_empty");
    check("udf_valid", 32'(bus.valid_out), 32'd0);
    check("udf_set", 32'(bus.underflow), 32'd1);
    cycle(1, 12'h055, 1, 0, "push_pop_empty");
    check("ppe_count", 32'(bus.count), 32'd1);
    cycle(1, 12'h0FF, 0, 1, "err_clr");
    check("clr_udf", 32'(bus.underflow), 32'd0);

    // Mid-operation reset with five entries
    repeat (3) cycle(1, WIDTH'($urandom), 0, 0, "pre_reset_fill");
    check("pre_reset_count", 32'(bus.count), 32'd5);
    reset = 1'b0;
    cycle(0, '0, 0, 0, "mid_reset");
    reset = 1'b1;
    check("mid_reset_count", 32'(bus.count), 32'd0);
    cycle(1, 12'h3C3, 0, 0, "post_reset_push");
    cycle(0, '0, 1, 0, "post_reset_pop");
    check("post_reset_data", 32'(bus.data_out), 32'h3C3);

    // Threshold changes act combinationally
    repeat (3) cycle(1, WIDTH'($urandom), 0, 0, "thr_fill");
    bus.af_thresh = 4'd3;
    #1;
    check("af_thr3", 32'(bus.almost_full), 32'd1);
    bus.ae_thresh = 4'd3;
    #1;
    check("ae_thr3", 32'(bus.almost_empty), 32'd1);
    check_all("thr_all");

    // Randomised traffic with biased phases to reach full and empty
    for (int i = 0; i < 800; i++) begin
      int bias;
      bias = ((i / 50) % 2 == 0) ? 75 : 25;
      if ($urandom_range(19, 0) == 0) begin
        bus.af_thresh = 4'($urandom_range(DEPTH, 0));
        bus.ae_thresh = 4'($urandom_range(DEPTH, 0));
      end
      reset = ($urandom_range(149, 0) == 0) ? 1'b0 : 1'b1;
      cycle(($urandom_range(99, 0) < bias), WIDTH'($urandom),
            ($urandom_range(99, 0) >= bias), ($urandom_range(15, 0) == 0), "rand");
    end
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
